// File: rtl/sprite_if.sv
// ============================================================================
// Module   : sprite_if
// Brief    : One sprite rectangle: top-left corner and exclusive right/bottom edges.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sprite_if #(
    parameter int X_POS_W = 10,
    parameter int Y_POS_W = 10
);
    logic [X_POS_W-1:0] x_pos;
    logic [Y_POS_W-1:0] y_pos;
    logic [X_POS_W-1:0] right;
    logic [Y_POS_W-1:0] bottom;

    modport master    (output x_pos, y_pos, right, bottom);
    modport slave     (input  x_pos, y_pos, right, bottom);
    modport render_mp (input  x_pos, y_pos, right, bottom);
endinterface

`default_nettype wire

// File: rtl/sprite_renderer.sv
// ============================================================================
// Module   : sprite_renderer
// Brief    : Per-frame sprite snapshot and 3-stage pixel colour pipeline.
//            Optional center net enabled by macro PONG_CENTER_NET_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_renderer #(
    parameter int                                   N_SPRITES    = 3,
    parameter int                                   X_POS_W      = 10,
    parameter int                                   Y_POS_W      = 10,
    parameter int                                   RGB_W        = 12,
    parameter int                                   SCREEN_H_RES = 640,
    parameter logic [RGB_W-1:0]                     BG_COLOR     = 12'h000,
    parameter logic [0:N_SPRITES-1][RGB_W-1:0]      SPRITE_COLOR = {12'hFFF, 12'hF00, 12'h0F0},
    parameter logic [RGB_W-1:0]                     NET_COLOR    = 12'h888,
    parameter int                                   NET_W        = 4
) (
    input  wire logic               clk_i,
    input  wire logic               rst_ni,
    input  wire logic               new_frame_i,
    sprite_if.render_mp             sprites_i [N_SPRITES],
    input  wire logic [X_POS_W-1:0] pixel_x_i,
    input  wire logic [Y_POS_W-1:0] pixel_y_i,
    input  wire logic               visible_i,
    input  wire logic               hsync_i,
    input  wire logic               vsync_i,
    output logic      [RGB_W-1:0]   rgb_o,
    output logic                    hsync_o,
    output logic                    vsync_o
);

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_t;

    state_t             r_state;

    logic [X_POS_W-1:0] w_sx [N_SPRITES];
    logic [Y_POS_W-1:0] w_sy [N_SPRITES];
    logic [X_POS_W-1:0] w_sr [N_SPRITES];
    logic [Y_POS_W-1:0] w_sb [N_SPRITES];

    logic [X_POS_W-1:0] r_sx [N_SPRITES];
    logic [Y_POS_W-1:0] r_sy [N_SPRITES];
    logic [X_POS_W-1:0] r_sr [N_SPRITES];
    logic [Y_POS_W-1:0] r_sb [N_SPRITES];

    logic [X_POS_W-1:0] r1_px;
    logic [Y_POS_W-1:0] r1_py;
    logic               r1_vis;
    logic [2:0]         r_hs;
    logic [2:0]         r_vs;

    logic [N_SPRITES-1:0] w_hit;
    logic [N_SPRITES-1:0] r2_hit;
    logic                 r2_vis;
    logic [RGB_W-1:0]     w_rgb;

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_spr
        assign w_sx[g] = sprites_i[g].x_pos;
        assign w_sy[g] = sprites_i[g].y_pos;
        assign w_sr[g] = sprites_i[g].right;
        assign w_sb[g] = sprites_i[g].bottom;
        // Exclusive right/bottom edges make empty or inverted rectangles never hit.
        assign w_hit[g] = (r_state == RUN)
                       && (r_sx[g] <= r1_px) && (r1_px < r_sr[g])
                       && (r_sy[g] <= r1_py) && (r1_py < r_sb[g]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= WAIT_FRAME;
            for (int i = 0; i < N_SPRITES; i++) begin
                r_sx[i] <= '0;
                r_sy[i] <= '0;
                r_sr[i] <= '0;
                r_sb[i] <= '0;
            end
        end else if (new_frame_i) begin
            r_state <= RUN;
            for (int i = 0; i < N_SPRITES; i++) begin
                r_sx[i] <= w_sx[i];
                r_sy[i] <= w_sy[i];
                r_sr[i] <= w_sr[i];
                r_sb[i] <= w_sb[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r1_px  <= '0;
            r1_py  <= '0;
            r1_vis <= 1'b0;
            r_hs   <= '0;
            r_vs   <= '0;
        end else begin
            r1_px  <= pixel_x_i;
            r1_py  <= pixel_y_i;
            r1_vis <= visible_i;
            r_hs   <= {r_hs[1:0], hsync_i};
            r_vs   <= {r_vs[1:0], vsync_i};
        end
    end

`ifdef PONG_CENTER_NET_EN
    localparam logic [X_POS_W-1:0] C_NET_LO = X_POS_W'(SCREEN_H_RES/2 - NET_W/2);
    localparam logic [X_POS_W-1:0] C_NET_HI = X_POS_W'(SCREEN_H_RES/2 + NET_W/2);

    logic r2_net;
    // Dashes are 16 lines on, 16 off; the net is hidden until the first snapshot.
    wire  w_net = (r_state == RUN) && (r1_px >= C_NET_LO) && (r1_px < C_NET_HI)
               && !r1_py[4];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r2_net <= 1'b0;
        else         r2_net <= w_net;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r2_hit <= '0;
            r2_vis <= 1'b0;
        end else begin
            r2_hit <= w_hit;
            r2_vis <= r1_vis;
        end
    end

    // Walk from highest to lowest index so the lowest-index hit is written last.
    always_comb begin
        w_rgb = BG_COLOR;
`ifdef PONG_CENTER_NET_EN
        if (r2_net) w_rgb = NET_COLOR;
`endif
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (r2_hit[i]) w_rgb = SPRITE_COLOR[i];
        end
        if (!r2_vis) w_rgb = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rgb_o <= '0;
        else         rgb_o <= w_rgb;
    end

    assign hsync_o = r_hs[2];
    assign vsync_o = r_vs[2];

endmodule

`default_nettype wire

// File: tb/tb_sprite_renderer.sv
// ============================================================================
// Module   : tb_sprite_renderer
// Brief    : Directed self-checking bench for sprite_renderer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sprite_renderer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        new_frame_i;
    logic [9:0]  pixel_x_i;
    logic [9:0]  pixel_y_i;
    logic        visible_i;
    logic        hsync_i;
    logic        vsync_i;
    logic [11:0] rgb_o;
    logic        hsync_o;
    logic        vsync_o;

    int n_err = 0;
    int n_chk = 0;

    localparam logic [11:0] C_BG  = 12'h000;
`ifdef PONG_CENTER_NET_EN
    localparam logic [11:0] C_NET = 12'h888;
`else
    localparam logic [11:0] C_NET = 12'h000;
`endif

    sprite_if #(.X_POS_W(10), .Y_POS_W(10)) u_spr [3] ();

    sprite_renderer u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .new_frame_i (new_frame_i),
        .sprites_i   (u_spr),
        .pixel_x_i   (pixel_x_i),
        .pixel_y_i   (pixel_y_i),
        .visible_i   (visible_i),
        .hsync_i     (hsync_i),
        .vsync_i     (vsync_i),
        .rgb_o       (rgb_o),
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_spr(input int idx, input logic [9:0] x, input logic [9:0] y,
                           input logic [9:0] r, input logic [9:0] b);
        case (idx)
            0: begin u_spr[0].x_pos = x; u_spr[0].y_pos = y; u_spr[0].right = r; u_spr[0].bottom = b; end
            1: begin u_spr[1].x_pos = x; u_spr[1].y_pos = y; u_spr[1].right = r; u_spr[1].bottom = b; end
            default: begin u_spr[2].x_pos = x; u_spr[2].y_pos = y; u_spr[2].right = r; u_spr[2].bottom = b; end
        endcase
    endtask

    task automatic pulse_frame();
        new_frame_i = 1'b1;
        tick();
        new_frame_i = 1'b0;
    endtask

    task automatic px_check(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic vis, input logic [11:0] exp);
        pixel_x_i = x;
        pixel_y_i = y;
        visible_i = vis;
        repeat (3) tick();
        check(tag, {20'h0, rgb_o}, {20'h0, exp});
    endtask

    logic [15:0] hs_pat;
    logic [15:0] vs_pat;

    initial begin
        rst_ni      = 1'b0;
        new_frame_i = 1'b0;
        pixel_x_i   = 10'd12;
        pixel_y_i   = 10'd25;
        visible_i   = 1'b1;
        hsync_i     = 1'b1;
        vsync_i     = 1'b1;
        for (int i = 0; i < 3; i++) set_spr(i, '0, '0, '0, '0);
        set_spr(0, 10'd10, 10'd20, 10'd15, 10'd30);

        repeat (4) tick();
        check("rst_rgb",   {20'h0, rgb_o}, 32'h0);
        check("rst_hsync", {31'h0, hsync_o}, 32'h0);
        check("rst_vsync", {31'h0, vsync_o}, 32'h0);

        hsync_i = 1'b0;
        vsync_i = 1'b0;
        rst_ni  = 1'b1;
        px_check("wait_frame_bg", 10'd12, 10'd25, 1'b1, C_BG);

        // Latency: isolate one sprite pixel between background pixels
        pulse_frame();
        px_check("lat_pre", 10'd0, 10'd0, 1'b1, C_BG);
        pixel_x_i = 10'd12; pixel_y_i = 10'd25;
        tick();
        pixel_x_i = 10'd0;  pixel_y_i = 10'd0;
        tick();
        check("lat_2cyc", {20'h0, rgb_o}, {20'h0, C_BG});
        tick();
        check("lat_3cyc", {20'h0, rgb_o}, 32'hFFF);
        tick();
        check("lat_4cyc", {20'h0, rgb_o}, {20'h0, C_BG});

        px_check("edge_right",  10'd15, 10'd25, 1'b1, C_BG);
        px_check("edge_bottom", 10'd12, 10'd30, 1'b1, C_BG);
        px_check("edge_left_in", 10'd10, 10'd29, 1'b1, 12'hFFF);

        // Tearing: live sprite moves but snapshot holds until next frame pulse
        set_spr(0, 10'd100, 10'd100, 10'd110, 10'd110);
        px_check("tear_old_in",  10'd12,  10'd25,  1'b1, 12'hFFF);
        px_check("tear_new_out", 10'd105, 10'd105, 1'b1, C_BG);
        pulse_frame();
        px_check("swap_new_in",  10'd105, 10'd105, 1'b1, 12'hFFF);
        px_check("swap_old_out", 10'd12,  10'd25,  1'b1, C_BG);

        // Priority
        set_spr(0, 10'd40, 10'd40, 10'd60, 10'd60);
        set_spr(1, 10'd0,  10'd0,  10'd5,  10'd5);
        set_spr(2, 10'd45, 10'd45, 10'd55, 10'd55);
        pulse_frame();
        px_check("prio_s0",   10'd50, 10'd50, 1'b1, 12'hFFF);
        px_check("spr1",      10'd2,  10'd2,  1'b1, 12'hF00);
        set_spr(0, '0, '0, '0, '0);
        pulse_frame();
        px_check("prio_s2",   10'd50, 10'd50, 1'b1, 12'h0F0);
        px_check("invisible", 10'd50, 10'd50, 1'b0, 12'h000);
        px_check("s2_only",   10'd42, 10'd50, 1'b1, C_BG);

        // Sync alignment
        hs_pat = 16'b1011_0010_1110_0101;
        vs_pat = 16'b0110_1001_0011_1100;
        for (int k = 0; k < 16; k++) begin
            hsync_i = hs_pat[k];
            vsync_i = vs_pat[k];
            tick();
            if (k >= 2) begin
                check("hsync_dly", {31'h0, hsync_o}, {31'h0, hs_pat[k-2]});
                check("vsync_dly", {31'h0, vsync_o}, {31'h0, vs_pat[k-2]});
            end
        end
        hsync_i = 1'b0;
        vsync_i = 1'b0;

        // Center net
        set_spr(1, '0, '0, '0, '0);
        set_spr(2, '0, '0, '0, '0);
        pulse_frame();
        px_check("net_320_0",  10'd320, 10'd0,  1'b1, C_NET);
        px_check("net_320_16", 10'd320, 10'd16, 1'b1, C_BG);
        px_check("net_318_5",  10'd318, 10'd5,  1'b1, C_NET);
        px_check("net_322_5",  10'd322, 10'd5,  1'b1, C_BG);
        px_check("net_317_5",  10'd317, 10'd5,  1'b1, C_BG);
        set_spr(1, 10'd316, 10'd0, 10'd324, 10'd8);
        pulse_frame();
        px_check("net_sprite", 10'd320, 10'd0, 1'b1, 12'hF00);

        // Asynchronous reset mid-frame clears output and drops the snapshot
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_rgb", {20'h0, rgb_o}, 32'h0);
        tick();
        rst_ni = 1'b1;
        px_check("post_rst_bg", 10'd320, 10'd0, 1'b1, C_BG);
        px_check("post_rst_bg2", 10'd318, 10'd5, 1'b1, C_BG);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
